id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with integrated hazard detection for the five-stage MIPS pipeline. Captures decode-stage control (from the controller) and operands every cycle. Detects load-use and ID-resolved-branch/jr data hazards, stalls PC and IF/ID, and injects a bubble into EX. Also keeps a saturating stall-cycle counter for performance checks.

## Interface
Parameters:
- `WIDTH`, 32, datapath width
- `RA_W`, 5, register-address width
- `CNT_W`, 16, stall counter width

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `opcode_id`  in  6  ID-stage opcode; encodings:
  - R=000000, addi=000001, slti=000010, lw=000011
  - sw=000100, beq=000101, j=000110, jr=000111, jal=001000
- `mem_read_id`, `mem_write_id`, `mem_to_reg_id`, `reg_dst_id`, `reg_write_id`  in  1 each  controller outputs
- `alu_op_id`, `alu_src_id`  in  2 each  controller outputs
- `flush`  in  1  squash the instruction entering EX this cycle
- `pc_plus4_id`, `rs_data_id`, `rt_data_id`, `imm_id`  in  WIDTH each  decode operands (imm already sign-extended)
- `rs_id`, `rt_id`, `rd_id`  in  RA_W each  register fields
- `funct_id`  in  6  function field
- `mem_read_mem`  in  1  EX/MEM holds a load
- `dst_mem`  in  RA_W  EX/MEM destination register
- `stall`  out  1  combinational; hazard detected
- `pc_write`, `if_id_write`  out  1 each  combinational; equal to ~stall
- `*_ex` registered outputs  out  same widths  one per ID input above, excluding `opcode_id`, `mem_read_mem`, `dst_mem`
- `dst_ex`  out  RA_W  registered; `reg_dst_id ? rd_id : rt_id`
- `valid_ex`  out  1  registered; EX holds a real instruction
- `stall_count`  out  CNT_W  saturating count of stall cycles

## Operation
Source usage is decoded from `opcode_id`:
- `uses_rs`: R, addi, slti, lw, sw, beq, jr
- `uses_rt`: R, sw, beq
- `id_resolves`: beq, jr

Source matching:
- `match(x)` = (x != 0) && ((x==rs_id && uses_rs) || (x==rt_id && uses_rt))

Hazards, OR-ed into `stall`:
- Load-use: `valid_ex && mem_read_ex && match(dst_ex)`.
- Branch after ALU op: `id_resolves && valid_ex && reg_write_ex && match(dst_ex)`.
- Branch after load, second cycle: `id_resolves && mem_read_mem && match(dst_mem)`.

A beq or jr directly after an lw therefore stalls two cycles. A beq or jr directly after an ALU op stalls one cycle.

Register update on each clk edge, in priority order:
1. `rst_n`=0 (asynchronous): every register is cleared to 0, including `valid_ex` and `stall_count`.
2. `flush`=1: bubble.
3. `stall`=1: bubble.
4. Otherwise: all `*_ex` load their `*_id` values, `dst_ex` loads the muxed destination, and `valid_ex`=1.

Bubble:
- Sets `mem_read_ex`, `mem_write_ex`, `mem_to_reg_ex`, `reg_dst_ex`, `reg_write_ex`, `alu_op_ex`, `alu_src_ex` and `valid_ex` to 0.
- Data and address fields still load from ID; they are don't-care downstream.

`stall_count` increments on every edge where `stall`=1 and `flush`=0. It saturates at all-ones and does not wrap.

A j, jal or jr in ID is not a hazard source; its control fields pass through unchanged.

## Timing
- `stall`, `pc_write`, `if_id_write` are combinational from the current ID inputs, the registered EX state, and `mem_read_mem`/`dst_mem`. They have no dependence on `flush`.
- ID to EX latency is one cycle.
- During a stall the ID instruction is held upstream: PC and IF/ID are frozen, and the ID inputs are re-presented next cycle.
- After the bubble the EX state no longer matches, so a load-use stall lasts exactly one cycle.
- `flush` and `stall` together: bubble; `stall` is still driven high; `stall_count` does not increment.
- Reset mid-stall: `stall` falls immediately, because `valid_ex`=0 and `mem_read_ex`=0. `mem_read_mem`/`dst_mem` are external and must also be cleared by their own owner.
- Source or destination register 0 never causes a hazard.

## Test plan
- Reset: assert `rst_n`=0 mid-run. Required: all `*_ex`=0, `valid_ex`=0, `stall_count`=0 with no clock edge; `stall`=0.
- Load-use: lw $2 in EX (`dst_ex`=2), then R-type with `rs_id`=2 in ID. Required: `stall`=1 for one cycle, `pc_write`=0, bubble in EX (`reg_write_ex`=0, `valid_ex`=0). The R-type enters EX on the next edge; `stall_count`=1.
- beq after lw:
  - Sequence: lw $3 in EX, then beq with `rt_id`=3.
  - Cycle 1: load-use stall.
  - Cycle 2: stall via `mem_read_mem`=1, `dst_mem`=3.
  - Cycle 3: beq enters EX, `stall_count`=2.
- No false hazard:
  - addi with `rt_id`=dst_ex after lw: no stall, since rt is not a source for addi.
  - R-type with `rs_id`=0 after a lw writing $0: no stall.
- Flush precedence: `flush`=1 while a load-use hazard is present. Required: bubble, `stall`=1, `stall_count` unchanged. Also `flush`=1 with no hazard: `valid_ex`=0 next cycle.
- Saturation: preload by holding a stall for 65536 cycles. Required: `stall_count`=16'hFFFF and it holds there.

Source files
------------

// File: rtl/id_ex_stage.sv
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode_id,
  input  logic             mem_read_id,
  input  logic             mem_write_id,
  input  logic             mem_to_reg_id,
  input  logic             reg_dst_id,
  input  logic             reg_write_id,
  input  logic [1:0]       alu_op_id,
  input  logic [1:0]       alu_src_id,
  input  logic             flush,
  input  logic [WIDTH-1:0] pc_plus4_id,
  input  logic [WIDTH-1:0] rs_data_id,
  input  logic [WIDTH-1:0] rt_data_id,
  input  logic [WIDTH-1:0] imm_id,
  input  logic [RA_W-1:0]  rs_id,
  input  logic [RA_W-1:0]  rt_id,
  input  logic [RA_W-1:0]  rd_id,
  input  logic [5:0]       funct_id,
  input  logic             mem_read_mem,
  input  logic [RA_W-1:0]  dst_mem,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             mem_read_ex,
  output logic             mem_write_ex,
  output logic             mem_to_reg_ex,
  output logic             reg_dst_ex,
  output logic             reg_write_ex,
  output logic [1:0]       alu_op_ex,
  output logic [1:0]       alu_src_ex,
  output logic [WIDTH-1:0] pc_plus4_ex,
  output logic [WIDTH-1:0] rs_data_ex,
  output logic [WIDTH-1:0] rt_data_ex,
  output logic [WIDTH-1:0] imm_ex,
  output logic [RA_W-1:0]  rs_ex,
  output logic [RA_W-1:0]  rt_ex,
  output logic [RA_W-1:0]  rd_ex,
  output logic [5:0]       funct_ex,
  output logic [RA_W-1:0]  dst_ex,
  output logic             valid_ex,
  output logic [CNT_W-1:0] stall_count
);
  // ID/EX pipeline register with load-use and
  // ID-branch hazard detection.

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_SLTI = 6'd2;
  localparam logic [5:0] OP_LW   = 6'd3;
  localparam logic [5:0] OP_SW   = 6'd4;
  localparam logic [5:0] OP_BEQ  = 6'd5;
  localparam logic [5:0] OP_JR   = 6'd7;

  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic [1:0]       alu_op;
    logic [1:0]       alu_src;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] imm;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [RA_W-1:0]  rd;
    logic [5:0]       funct;
    logic [RA_W-1:0]  dst;
    logic             valid;
  } ex_t;

  ex_t              ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             uses_rs, uses_rt, id_res;
  logic             m_ex, m_mem;
  logic             hz_lu, hz_br, hz_bl;

  // Decode which sources the ID instruction reads.
  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    id_res  = 1'b0;
    unique case (opcode_id)
      OP_R:    begin uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_ADDI: uses_rs = 1'b1;
      OP_SLTI: uses_rs = 1'b1;
      OP_LW:   uses_rs = 1'b1;
      OP_SW:   begin uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_BEQ:  begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        id_res  = 1'b1;
      end
      OP_JR:   begin uses_rs = 1'b1; id_res = 1'b1; end
      default: ;
    endcase
  end

  function automatic logic match(
    input logic [RA_W-1:0] x,
    input logic [RA_W-1:0] rs,
    input logic [RA_W-1:0] rt,
    input logic            urs,
    input logic            urt
  );
    return (x != '0) &&
           ((x == rs && urs) || (x == rt && urt));
  endfunction

  // Hazard detection; independent of flush.
  always_comb begin
    m_ex  = match(ex_q.dst, rs_id, rt_id,
                  uses_rs, uses_rt);
    m_mem = match(dst_mem, rs_id, rt_id,
                  uses_rs, uses_rt);
    hz_lu = ex_q.valid && ex_q.mem_read && m_ex;
    hz_br = id_res && ex_q.valid &&
            ex_q.reg_write && m_ex;
    hz_bl = id_res && mem_read_mem && m_mem;
    stall = hz_lu || hz_br || hz_bl;
  end

  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  // Next EX state: capture ID, bubble on flush or stall.
  always_comb begin
    ex_d.mem_read   = mem_read_id;
    ex_d.mem_write  = mem_write_id;
    ex_d.mem_to_reg = mem_to_reg_id;
    ex_d.reg_dst    = reg_dst_id;
    ex_d.reg_write  = reg_write_id;
    ex_d.alu_op     = alu_op_id;
    ex_d.alu_src    = alu_src_id;
    ex_d.pc_plus4   = pc_plus4_id;
    ex_d.rs_data    = rs_data_id;
    ex_d.rt_data    = rt_data_id;
    ex_d.imm        = imm_id;
    ex_d.rs         = rs_id;
    ex_d.rt         = rt_id;
    ex_d.rd         = rd_id;
    ex_d.funct      = funct_id;
    ex_d.dst        = reg_dst_id ? rd_id : rt_id;
    ex_d.valid      = 1'b1;
    if (flush || stall) begin
      ex_d.mem_read   = 1'b0;
      ex_d.mem_write  = 1'b0;
      ex_d.mem_to_reg = 1'b0;
      ex_d.reg_dst    = 1'b0;
      ex_d.reg_write  = 1'b0;
      ex_d.alu_op     = 2'b00;
      ex_d.alu_src    = 2'b00;
      ex_d.valid      = 1'b0;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && !flush && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  // EX register and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign mem_read_ex   = ex_q.mem_read;
  assign mem_write_ex  = ex_q.mem_write;
  assign mem_to_reg_ex = ex_q.mem_to_reg;
  assign reg_dst_ex    = ex_q.reg_dst;
  assign reg_write_ex  = ex_q.reg_write;
  assign alu_op_ex     = ex_q.alu_op;
  assign alu_src_ex    = ex_q.alu_src;
  assign pc_plus4_ex   = ex_q.pc_plus4;
  assign rs_data_ex    = ex_q.rs_data;
  assign rt_data_ex    = ex_q.rt_data;
  assign imm_ex        = ex_q.imm;
  assign rs_ex         = ex_q.rs;
  assign rt_ex         = ex_q.rt;
  assign rd_ex         = ex_q.rd;
  assign funct_ex      = ex_q.funct;
  assign dst_ex        = ex_q.dst;
  assign valid_ex      = ex_q.valid;
  assign stall_count   = cnt_q;

endmodule
